// File: rtl/fast_frame_sequencer.sv
// fast_frame_sequencer
//   Frame-level controller between the VDMA MM2S stream and the FAST/NMS
//   corner pipeline. A start pulse arms one frame. Stale beats are dropped
//   until SOF, the SOF beat gets the frame geometry stamped in, and the rest
//   of the frame is forwarded with line ends regenerated from the geometry.
//   The pipeline output is tapped to count corners and TLASTs, and the block
//   reports completion, error or drain timeout.
// Ports:
//   aclk, areset         clock, synchronous active-high reset
//   cfg_w, cfg_h         frame geometry, sampled on an accepted start
//   start, abort         arm pulse (IDLE/ERR only), force-to-IDLE
//   s_axis_*             input stream from VDMA (tuser = SOF)
//   d_axis_*             output stream to the pipeline (combinational path)
//   r_axis_*             observe-only tap of the pipeline output
//   busy, done, error    registered status
//   err_code             0 none, 1 geometry, 2 line length, 3 early SOF, 4 timeout
//   corner_cnt           saturating corner count for the current frame
//   frame_cnt            completed frames, wraps
module fast_frame_sequencer #(
  parameter int unsigned     MAX_W          = 1024,
  parameter int unsigned     MAX_H          = 768,
  parameter bit              TLAST_EACH_ROW = 1'b1,
  parameter int unsigned     TO_W           = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYC    = {TO_W{1'b1}}
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [15:0] cfg_w,
  input  logic [15:0] cfg_h,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [63:0] d_axis_tdata,
  output logic        d_axis_tvalid,
  input  logic        d_axis_tready,
  output logic        d_axis_tlast,
  output logic        d_axis_tuser,
  input  logic        r_axis_tvalid,
  input  logic        r_axis_tready,
  input  logic        r_axis_tlast,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [31:0] corner_cnt,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SOF, S_STREAM, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t            state, state_n;
  logic [15:0]       w, h, x, y, tl_cnt, exp_tl;
  logic [TO_W-1:0]   to_cnt;
  logic [15:0]       w_c, h_c;
  logic [2:0]        err_n;
  logic              s_acc, r_hs, mon_active, tl_inc, tl_hit;
  logic              x_last, y_last, start_acc;

  assign w_c = (32'(cfg_w) > MAX_W) ? 16'(MAX_W) : cfg_w;
  assign h_c = (32'(cfg_h) > MAX_H) ? 16'(MAX_H) : cfg_h;

  assign s_acc      = s_axis_tvalid & s_axis_tready;
  assign r_hs       = r_axis_tvalid & r_axis_tready;
  assign mon_active = (state == S_WAIT_SOF) || (state == S_STREAM) || (state == S_DRAIN);
  assign tl_inc     = mon_active & r_hs & r_axis_tlast;
  // Completion compares against the count including this cycle's TLAST so
  // done follows the final TLAST by exactly one cycle.
  assign tl_hit     = ((tl_cnt + 16'(tl_inc)) == exp_tl);
  assign x_last     = (x == (w - 16'd1));
  assign y_last     = (y == (h - 16'd1));
  assign start_acc  = start & ~abort & ((state == S_IDLE) || (state == S_ERR));

  always_comb begin
    s_axis_tready = 1'b0;
    d_axis_tvalid = 1'b0;
    d_axis_tlast  = 1'b0;
    d_axis_tuser  = 1'b0;
    d_axis_tdata  = s_axis_tdata;
    state_n       = state;
    err_n         = 3'd0;

    case (state)
      S_WAIT_SOF: begin
        // Stale beats are swallowed; only the SOF beat waits for the sink.
        s_axis_tready        = s_axis_tuser ? d_axis_tready : 1'b1;
        d_axis_tvalid        = s_axis_tvalid & s_axis_tuser;
        d_axis_tuser         = s_axis_tuser;
        d_axis_tdata[39:24]  = w;
        d_axis_tdata[23:8]   = h;
        if (s_acc && s_axis_tuser) state_n = S_STREAM;
      end
      S_STREAM: begin
        // An unexpected SOF is consumed but never reaches the pipeline.
        s_axis_tready = s_axis_tuser ? 1'b1 : d_axis_tready;
        d_axis_tvalid = s_axis_tvalid & ~s_axis_tuser;
        d_axis_tlast  = x_last;
        if (s_acc) begin
          if (s_axis_tuser) begin
            state_n = S_ERR;
            err_n   = 3'd3;
          end else if (s_axis_tlast != x_last) begin
            state_n = S_ERR;
            err_n   = 3'd2;
          end else if (x_last && y_last) begin
            state_n = tl_hit ? S_DONE : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (to_cnt == TIMEOUT_CYC) begin
          state_n = S_ERR;
          err_n   = 3'd4;
        end else if (tl_hit) begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = state;
    endcase

    if (start_acc) begin
      if ((w_c >= 16'd3) && (h_c >= 16'd3)) begin
        state_n = S_WAIT_SOF;
      end else begin
        state_n = S_ERR;
        err_n   = 3'd1;
      end
    end

    if (abort) begin
      state_n = S_IDLE;
      err_n   = 3'd0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= S_IDLE;
      w          <= '0;
      h          <= '0;
      x          <= '0;
      y          <= '0;
      tl_cnt     <= '0;
      exp_tl     <= '0;
      to_cnt     <= '0;
      corner_cnt <= '0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n == S_WAIT_SOF) || (state_n == S_STREAM) || (state_n == S_DRAIN);
      done  <= (state_n == S_DONE);

      if (mon_active && r_hs) begin
        if (r_axis_tlast) tl_cnt <= tl_cnt + 16'd1;
        else if (corner_cnt != '1) corner_cnt <= corner_cnt + 32'd1;
      end

      if ((state == S_DRAIN) && !r_hs) to_cnt <= to_cnt + TO_W'(1);
      else to_cnt <= '0;

      if (s_acc) begin
        if ((state == S_WAIT_SOF) && s_axis_tuser) begin
          x <= 16'd1;
          y <= '0;
        end else if ((state == S_STREAM) && !s_axis_tuser) begin
          if (x_last) begin
            x <= '0;
            y <= y + 16'd1;
          end else begin
            x <= x + 16'd1;
          end
        end
      end

      if (state_n == S_DONE) frame_cnt <= frame_cnt + 16'd1;

      if (start_acc) begin
        w          <= w_c;
        h          <= h_c;
        exp_tl     <= TLAST_EACH_ROW ? (h_c - 16'd2) : 16'd1;
        tl_cnt     <= '0;
        corner_cnt <= '0;
        error      <= 1'b0;
        err_code   <= '0;
      end

      if (err_n != 3'd0) begin
        error    <= 1'b1;
        err_code <= err_n;
      end

      if (abort) begin
        error    <= 1'b0;
        err_code <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fast_frame_sequencer.sv
// Testbench for fast_frame_sequencer: geometry table, frame sequences,
// scoreboard of forwarded beats. Two instances: dut_a (row TLASTs, long
// timeout) and dut_b (frame TLAST, 16-cycle timeout) share inputs except start.
`timescale 1ns/1ps
module tb_fast_frame_sequencer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] cfg_w = '0, cfg_h = '0;
  logic        start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic        d_tready = 1'b1;
  logic        r_tvalid = 1'b0, r_tready = 1'b0, r_tlast = 1'b0;

  logic        s_tready_a, d_tvalid_a, d_tlast_a, d_tuser_a, busy_a, done_a, error_a;
  logic [63:0] d_tdata_a;
  logic [2:0]  err_code_a;
  logic [31:0] corner_a;
  logic [15:0] frame_a;
  logic        s_tready_b, d_tvalid_b, d_tlast_b, d_tuser_b, busy_b, done_b, error_b;
  logic [63:0] d_tdata_b;
  logic [2:0]  err_code_b;
  logic [31:0] corner_b;
  logic [15:0] frame_b;

  logic        sel = 1'b0;
  logic        o_s_tready, o_d_tvalid, o_d_tlast, o_d_tuser, o_busy, o_done, o_error;
  logic [63:0] o_d_tdata;
  logic [2:0]  o_err_code;
  logic [31:0] o_corner;
  logic [15:0] o_frame;

  always #5 aclk = ~aclk;

  fast_frame_sequencer #(.TLAST_EACH_ROW(1'b1), .TIMEOUT_CYC(24'd300)) dut_a (
    .aclk(aclk), .areset(areset), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .start(start_a), .abort(abort),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_a),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .d_axis_tdata(d_tdata_a), .d_axis_tvalid(d_tvalid_a), .d_axis_tready(d_tready),
    .d_axis_tlast(d_tlast_a), .d_axis_tuser(d_tuser_a),
    .r_axis_tvalid(r_tvalid), .r_axis_tready(r_tready), .r_axis_tlast(r_tlast),
    .busy(busy_a), .done(done_a), .error(error_a), .err_code(err_code_a),
    .corner_cnt(corner_a), .frame_cnt(frame_a));

  fast_frame_sequencer #(.TLAST_EACH_ROW(1'b0), .TIMEOUT_CYC(24'd16)) dut_b (
    .aclk(aclk), .areset(areset), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .start(start_b), .abort(abort),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_b),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .d_axis_tdata(d_tdata_b), .d_axis_tvalid(d_tvalid_b), .d_axis_tready(d_tready),
    .d_axis_tlast(d_tlast_b), .d_axis_tuser(d_tuser_b),
    .r_axis_tvalid(r_tvalid), .r_axis_tready(r_tready), .r_axis_tlast(r_tlast),
    .busy(busy_b), .done(done_b), .error(error_b), .err_code(err_code_b),
    .corner_cnt(corner_b), .frame_cnt(frame_b));

  always_comb begin
    if (sel) begin
      o_s_tready = s_tready_b; o_d_tvalid = d_tvalid_b; o_d_tlast = d_tlast_b;
      o_d_tuser = d_tuser_b; o_d_tdata = d_tdata_b; o_busy = busy_b; o_done = done_b;
      o_error = error_b; o_err_code = err_code_b; o_corner = corner_b; o_frame = frame_b;
    end else begin
      o_s_tready = s_tready_a; o_d_tvalid = d_tvalid_a; o_d_tlast = d_tlast_a;
      o_d_tuser = d_tuser_a; o_d_tdata = d_tdata_a; o_busy = busy_a; o_done = done_a;
      o_error = error_a; o_err_code = err_code_a; o_corner = corner_a; o_frame = frame_a;
    end
  end

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    logic [15:0] cw, ch;
    logic        busy, err;
    logic [2:0]  code;
    logic [15:0] hw, hh;
  } geo_t;

  beat_t sb_q[$];
  int    checks = 0, failures = 0;
  int    dlast_cnt = 0, done_cnt = 0;
  bit    bp_mode = 1'b0;

  // Scoreboard: every cycle the sink sees a valid beat it must match the
  // head of the queue; the head is retired only on an actual handshake.
  initial forever begin
    @(negedge aclk);
    if (!areset && o_done) done_cnt++;
    if (!areset && o_d_tvalid) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL d_beat_unexpected: got data=%h last=%b user=%b want no beat",
                 o_d_tdata, o_d_tlast, o_d_tuser);
      end else if ({o_d_tdata, o_d_tlast, o_d_tuser} !== sb_q[0]) begin
        failures++;
        $display("FAIL d_beat: got data=%h last=%b user=%b want data=%h last=%b user=%b",
                 o_d_tdata, o_d_tlast, o_d_tuser, sb_q[0].data, sb_q[0].last, sb_q[0].user);
      end
      if (d_tready) begin
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        if (o_d_tlast) dlast_cnt++;
      end
    end
  end

  initial forever begin
    @(posedge aclk);
    #1;
    if (bp_mode) d_tready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start(input logic b, input logic [15:0] cw, input logic [15:0] ch);
    cfg_w = cw;
    cfg_h = ch;
    if (b) start_b = 1'b1;
    else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] data, input logic last, input logic user);
    bit ok = 1'b0;
    s_tdata  = data;
    s_tlast  = last;
    s_tuser  = user;
    s_tvalid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk);
      if (o_s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL s_accept: got no s_tready want handshake within 400 cycles");
    end
  endtask

  task automatic mon_beat(input logic last);
    r_tvalid = 1'b1;
    r_tready = 1'b1;
    r_tlast  = last;
    tick();
    r_tvalid = 1'b0;
    r_tready = 1'b0;
    r_tlast  = 1'b0;
  endtask

  // Sends junk beats then pixels 0..last_p of a w-wide frame; bad_x forces a
  // wrong s_tlast at that column. Expected forwarded beats go to the queue.
  task automatic send_frame(input int w, input int junk, input int bad_x, input int last_p,
                            input logic [15:0] hw, input logic [15:0] hh);
    logic [63:0] dat;
    for (int j = 0; j < junk; j++) send_beat({$urandom, $urandom}, 1'b0, 1'b0);
    for (int p = 0; p <= last_p; p++) begin
      int px;
      px  = p % w;
      dat = {$urandom, $urandom};
      if (p == 0) sb_q.push_back({dat[63:40], hw, hh, dat[7:0], 1'b0, 1'b1});
      else sb_q.push_back({dat, (px == w - 1), 1'b0});
      send_beat(dat, (px == w - 1) || (px == bad_x), (p == 0));
    end
  endtask

  geo_t geo[6];
  int   base_dl, base_done, cyc;
  logic [63:0] dat;

  initial begin
    geo[0] = '{16'd2,    16'd6,   1'b0, 1'b1, 3'd1, 16'd0,    16'd0};
    geo[1] = '{16'd8,    16'd2,   1'b0, 1'b1, 3'd1, 16'd0,    16'd0};
    geo[2] = '{16'd0,    16'd0,   1'b0, 1'b1, 3'd1, 16'd0,    16'd0};
    geo[3] = '{16'd3,    16'd3,   1'b1, 1'b0, 3'd0, 16'd3,    16'd3};
    geo[4] = '{16'd2000, 16'd900, 1'b1, 1'b0, 3'd0, 16'd1024, 16'd768};
    geo[5] = '{16'd1024, 16'd768, 1'b1, 1'b0, 3'd0, 16'd1024, 16'd768};

    // Reset values, with an SOF beat presented during reset.
    repeat (2) tick();
    s_tvalid = 1'b1;
    s_tuser  = 1'b1;
    tick();
    check("rst_s_tready", o_s_tready, 1'b0);
    check("rst_d_tvalid", o_d_tvalid, 1'b0);
    check("rst_d_tlast", o_d_tlast, 1'b0);
    check("rst_d_tuser", o_d_tuser, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_error", o_error, 1'b0);
    check("rst_err_code", o_err_code, 3'd0);
    check("rst_corner", o_corner, 32'd0);
    check("rst_frame", o_frame, 16'd0);
    check("rst_b_s_tready", s_tready_b, 1'b0);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    areset   = 1'b0;
    tick();

    // Geometry table: clamping, minimum size, header stamp.
    for (int i = 0; i < 6; i++) begin
      pulse_start(1'b0, geo[i].cw, geo[i].ch);
      check($sformatf("geo%0d_busy", i), o_busy, geo[i].busy);
      check($sformatf("geo%0d_error", i), o_error, geo[i].err);
      check($sformatf("geo%0d_code", i), o_err_code, geo[i].code);
      if (geo[i].busy) begin
        dat = {$urandom, $urandom};
        sb_q.push_back({dat[63:40], geo[i].hw, geo[i].hh, dat[7:0], 1'b0, 1'b1});
        send_beat(dat, 1'b0, 1'b1);
        check($sformatf("geo%0d_sof_busy", i), o_busy, 1'b1);
      end else begin
        check($sformatf("geo%0d_s_tready", i), o_s_tready, 1'b0);
      end
      pulse_abort();
      check($sformatf("geo%0d_abort_error", i), o_error, 1'b0);
      check($sformatf("geo%0d_abort_busy", i), o_busy, 1'b0);
    end

    // Nominal 8x6 frame with junk ahead of SOF.
    base_dl   = dlast_cnt;
    base_done = done_cnt;
    pulse_start(1'b0, 16'd8, 16'd6);
    check("nom_busy", o_busy, 1'b1);
    send_frame(8, 3, -1, 47, 16'd8, 16'd6);
    check("nom_sb_empty", sb_q.size(), 0);
    check("nom_dlast", dlast_cnt - base_dl, 6);
    check("nom_drain_busy", o_busy, 1'b1);
    repeat (5) mon_beat(1'b0);
    r_tvalid = 1'b1;
    tick();
    r_tvalid = 1'b0;
    repeat (3) mon_beat(1'b1);
    check("nom_done_early", o_done, 1'b0);
    check("nom_corner", o_corner, 32'd5);
    mon_beat(1'b1);
    check("nom_done", o_done, 1'b1);
    check("nom_frame", o_frame, 16'd1);
    tick();
    check("nom_done_pulse", o_done, 1'b0);
    check("nom_idle", o_busy, 1'b0);
    check("nom_done_count", done_cnt - base_done, 1);

    // Backpressure, with the final TLAST arriving long after the last pixel.
    base_dl   = dlast_cnt;
    base_done = done_cnt;
    bp_mode   = 1'b1;
    pulse_start(1'b0, 16'd8, 16'd6);
    send_frame(8, 3, -1, 47, 16'd8, 16'd6);
    bp_mode  = 1'b0;
    d_tready = 1'b1;
    check("bp_sb_empty", sb_q.size(), 0);
    check("bp_dlast", dlast_cnt - base_dl, 6);
    repeat (5) mon_beat(1'b0);
    repeat (3) mon_beat(1'b1);
    repeat (100) tick();
    check("bp_no_done", done_cnt - base_done, 0);
    check("bp_busy", o_busy, 1'b1);
    mon_beat(1'b1);
    check("bp_done", o_done, 1'b1);
    check("bp_frame", o_frame, 16'd2);
    check("bp_corner", o_corner, 32'd5);
    tick();

    // Line-length error: s_tlast at x=5 of an 8-wide row.
    pulse_start(1'b0, 16'd8, 16'd6);
    send_frame(8, 0, 5, 5, 16'd8, 16'd6);
    check("len_error", o_error, 1'b1);
    check("len_code", o_err_code, 3'd2);
    check("len_busy", o_busy, 1'b0);
    check("len_s_tready", o_s_tready, 1'b0);
    check("len_sb_empty", sb_q.size(), 0);
    pulse_abort();
    check("len_abort_error", o_error, 1'b0);
    check("len_abort_code", o_err_code, 3'd0);

    // Drain timeout on the 16-cycle instance.
    sel = 1'b1;
    pulse_start(1'b1, 16'd4, 16'd3);
    send_frame(4, 0, -1, 11, 16'd4, 16'd3);
    check("to_no_error_yet", o_error, 1'b0);
    cyc = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (o_error) begin
        cyc = n;
        break;
      end
    end
    check("to_cycles", cyc, 17);
    check("to_code", o_err_code, 3'd4);
    check("to_busy", o_busy, 1'b0);
    pulse_start(1'b1, 16'd2, 16'd6);
    check("badw_error", o_error, 1'b1);
    check("badw_code", o_err_code, 3'd1);
    pulse_abort();

    // Width clamp in frame-TLAST mode.
    base_dl = dlast_cnt;
    pulse_start(1'b1, 16'd2000, 16'd3);
    send_frame(1024, 2, -1, 3071, 16'd1024, 16'd3);
    check("clamp_sb_empty", sb_q.size(), 0);
    check("clamp_dlast", dlast_cnt - base_dl, 3);
    check("clamp_busy", o_busy, 1'b1);
    mon_beat(1'b1);
    check("clamp_done", o_done, 1'b1);
    check("clamp_frame", o_frame, 16'd1);
    check("clamp_corner", o_corner, 32'd0);
    tick();
    check("clamp_done_pulse", o_done, 1'b0);

    // Abort mid-STREAM keeps counters and produces no done.
    sel       = 1'b0;
    base_done = done_cnt;
    pulse_start(1'b0, 16'd8, 16'd6);
    send_frame(8, 0, -1, 10, 16'd8, 16'd6);
    repeat (2) mon_beat(1'b0);
    check("abort_pre_busy", o_busy, 1'b1);
    pulse_abort();
    check("abort_busy", o_busy, 1'b0);
    check("abort_s_tready", o_s_tready, 1'b0);
    repeat (5) tick();
    check("abort_no_done", done_cnt - base_done, 0);
    check("abort_frame", o_frame, 16'd2);
    check("abort_corner_kept", o_corner, 32'd2);

    // Reset mid-frame.
    pulse_start(1'b0, 16'd8, 16'd6);
    send_frame(8, 0, -1, 3, 16'd8, 16'd6);
    mon_beat(1'b0);
    areset = 1'b1;
    tick();
    check("mrst_busy", o_busy, 1'b0);
    check("mrst_frame", o_frame, 16'd0);
    check("mrst_corner", o_corner, 32'd0);
    check("mrst_s_tready", o_s_tready, 1'b0);
    areset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
